// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result-bus arbiter slice.
package alu_pkg;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  localparam logic [NUM_SRC-1:0] SEL_NONE = 4'b0000;

  // Index of the source after i, wrapping modulo NUM_SRC.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return i + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first set request at ptr, ptr+1, ... mod 4.
module rr_pick
  import alu_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [1:0]         i_ptr,
  output logic [NUM_SRC-1:0] o_grant,
  output logic [1:0]         o_idx
);

  logic [1:0] w_pos;

  // Scan farthest-first so the nearest requester to ptr is the last write.
  always_comb begin
    o_grant = SEL_NONE;
    o_idx   = 2'd0;
    w_pos   = 2'd0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      w_pos = i_ptr + 2'(k);
      if (i_req[w_pos]) begin
        o_grant        = SEL_NONE;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/selector.sv
// One-hot 4:1 bus selector; an all-zero select drives zero onto the bus.
module selector
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [NUM_SRC-1:0] i_sel,
  input  logic [DATA_W-1:0]  i_d0,
  input  logic [DATA_W-1:0]  i_d1,
  input  logic [DATA_W-1:0]  i_d2,
  input  logic [DATA_W-1:0]  i_d3,
  output logic [DATA_W-1:0]  o_y
);

  assign o_y = ({DATA_W{i_sel[0]}} & i_d0) |
               ({DATA_W{i_sel[1]}} & i_d1) |
               ({DATA_W{i_sel[2]}} & i_d2) |
               ({DATA_W{i_sel[3]}} & i_d3);

endmodule

// File: rtl/alu_bus_arbiter.sv
// Round-robin arbiter for the shared ALU result bus with a registered
// valid/ready output stage and a per-grant burst limit.
module alu_bus_arbiter
  import alu_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SRC-1:0]  req,
  input  logic [DATA_W-1:0]   data0,
  input  logic [DATA_W-1:0]   data1,
  input  logic [DATA_W-1:0]   data2,
  input  logic [DATA_W-1:0]   data3,
  output logic [NUM_SRC-1:0]  ack,
  output logic [NUM_SRC-1:0]  sel,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [NUM_SRC-1:0]  r_sel;
  logic [1:0]          r_gidx;
  logic [1:0]          r_ptr;
  logic [3:0]          r_cnt;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;

  logic [NUM_SRC-1:0]  w_pick;
  logic [1:0]          w_pick_idx;
  logic [DATA_W-1:0]   w_bus;
  logic                w_start;
  logic                w_req_g;
  logic                w_accept;
  logic                w_release;

  rr_pick u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick),
    .o_idx   (w_pick_idx)
  );

  selector #(.DATA_W(DATA_W)) u_sel (
    .i_sel (r_sel),
    .i_d0  (data0),
    .i_d1  (data1),
    .i_d2  (data2),
    .i_d3  (data3),
    .o_y   (w_bus)
  );

  // A stall on the output stage blocks accept but never releases the grant.
  assign w_start   = (r_state == ARB_IDLE) && (req != SEL_NONE);
  assign w_req_g   = |(req & r_sel);
  assign w_accept  = (r_state == ARB_GRANT) && w_req_g && (!r_out_valid || out_ready);
  assign w_release = (r_state == ARB_GRANT) &&
                     (!w_req_g || (w_accept && (r_cnt == LAST_CNT)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARB_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and accept decode.
  always_comb begin
    w_state_nxt = r_state;
    ack         = SEL_NONE;
    case (r_state)
      ARB_IDLE:  if (w_start) w_state_nxt = ARB_GRANT;
      ARB_GRANT: begin
        if (w_accept)  ack         = r_sel;
        if (w_release) w_state_nxt = ARB_IDLE;
      end
      default:   w_state_nxt = ARB_IDLE;
    endcase
  end

  // Grant select, rotation pointer and burst counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel  <= SEL_NONE;
      r_gidx <= 2'd0;
      r_ptr  <= 2'd0;
      r_cnt  <= 4'd0;
    end else if (w_start) begin
      r_sel  <= w_pick;
      r_gidx <= w_pick_idx;
      r_cnt  <= 4'd0;
    end else if (w_release) begin
      r_sel  <= SEL_NONE;
      r_ptr  <= next_idx(r_gidx);
    end else if (w_accept) begin
      r_cnt  <= r_cnt + 4'd1;
    end
  end

  // Output stage: load on accept, drain when consumed with nothing new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_data  <= w_bus;
      r_out_valid <= 1'b1;
    end else if (out_ready && r_out_valid) begin
      r_out_valid <= 1'b0;
    end
  end

  assign sel       = r_sel;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = (r_state == ARB_GRANT);

endmodule

// File: tb/tb_alu_bus_arbiter.sv
// Bench for alu_bus_arbiter: two instances (burst 4 and burst 1) share the
// same stimulus and are compared every cycle against a transfer-level model.
module tb_alu_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] d [4];
  logic       out_ready;

  logic [3:0] ack_o   [2];
  logic [3:0] sel_o   [2];
  logic [7:0] odata_o [2];
  logic       ovld_o  [2];
  logic       busy_o  [2];

  int n_checks = 0;
  int n_errors = 0;

  // Model state per instance: granted source (-1 = idle), rotation start,
  // transfers taken in this grant, and the byte held for the consumer.
  int   m_g   [2];
  int   m_ptr [2];
  int   m_cnt [2];
  int   m_od  [2];
  bit   m_ov  [2];
  int   m_burst [2] = '{4, 1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_bus_arbiter #(.MAX_BURST(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .data0(d[0]), .data1(d[1]), .data2(d[2]), .data3(d[3]),
    .ack(ack_o[0]), .sel(sel_o[0]), .out_data(odata_o[0]),
    .out_valid(ovld_o[0]), .out_ready(out_ready), .busy(busy_o[0])
  );

  alu_bus_arbiter #(.MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .data0(d[0]), .data1(d[1]), .data2(d[2]), .data3(d[3]),
    .ack(ack_o[1]), .sel(sel_o[1]), .out_data(odata_o[1]),
    .out_valid(ovld_o[1]), .out_ready(out_ready), .busy(busy_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_g[m] = -1; m_ptr[m] = 0; m_cnt[m] = 0; m_od[m] = 0; m_ov[m] = 0;
    end
  endtask

  task automatic chk_reset_values();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst_sel%0d", m),   32'(sel_o[m]),   32'h0);
      chk($sformatf("rst_ack%0d", m),   32'(ack_o[m]),   32'h0);
      chk($sformatf("rst_data%0d", m),  32'(odata_o[m]), 32'h0);
      chk($sformatf("rst_valid%0d", m), 32'(ovld_o[m]),  32'h0);
      chk($sformatf("rst_busy%0d", m),  32'(busy_o[m]),  32'h0);
    end
  endtask

  // Compare the current cycle against the model, then advance the model by
  // one clock edge using the inputs presently applied.
  task automatic step();
    int  g, w;
    bit  acc;
    logic [3:0] e_sel, e_ack;
    #1;
    for (int m = 0; m < 2; m++) begin
      g     = m_g[m];
      acc   = (g >= 0) && req[g] && (!m_ov[m] || out_ready);
      e_sel = (g >= 0) ? 4'(1 << g) : 4'h0;
      e_ack = acc ? e_sel : 4'h0;
      chk($sformatf("sel%0d", m),   32'(sel_o[m]),   32'(e_sel));
      chk($sformatf("ack%0d", m),   32'(ack_o[m]),   32'(e_ack));
      chk($sformatf("busy%0d", m),  32'(busy_o[m]),  32'(g >= 0));
      chk($sformatf("valid%0d", m), 32'(ovld_o[m]),  32'(m_ov[m]));
      chk($sformatf("data%0d", m),  32'(odata_o[m]), 32'(m_od[m]));
      chk($sformatf("onehot%0d", m), 32'($onehot0(sel_o[m]) && $onehot0(ack_o[m])), 32'h1);
      if (g < 0) begin
        if (m_ov[m] && out_ready) m_ov[m] = 0;
        if (req != 4'h0) begin
          w = -1;
          for (int k = 3; k >= 0; k--)
            if (req[(m_ptr[m] + k) % 4]) w = (m_ptr[m] + k) % 4;
          m_g[m]   = w;
          m_cnt[m] = 0;
        end
      end else begin
        if (acc) begin
          m_od[m] = int'(d[g]);
          m_ov[m] = 1;
        end else if (m_ov[m] && out_ready) begin
          m_ov[m] = 0;
        end
        if (!req[g] || (acc && m_cnt[m] == m_burst[m] - 1)) begin
          m_ptr[m] = (g + 1) % 4;
          m_g[m]   = -1;
        end else if (acc) begin
          m_cnt[m]++;
        end
      end
    end
    @(negedge clk);
  endtask

  // Assert reset between clock edges and check the outputs fall immediately.
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1 chk_reset_values();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 4; i++) begin
      if (req[i]) begin
        if ($urandom_range(0, 4) == 0) req[i] = 1'b0;
      end else begin
        d[i] = 8'($urandom);
        if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
      end
    end
    out_ready = ($urandom_range(0, 9) < 7);
  endtask

  initial begin
    rst_n = 1'b0; req = 4'h0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    #1 chk_reset_values();
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester, first-transfer latency.
    req = 4'b0001; d[0] = 8'hA5; out_ready = 1'b1;
    repeat (4) step();
    req = 4'b0000;
    repeat (2) step();

    // All sources requesting: rotation and burst length.
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    req = 4'b1111;
    repeat (25) step();

    // Reset in the middle of a burst with a byte held.
    async_reset();

    // Grant to source 2, then a five-cycle consumer stall.
    req = 4'b0100; d[2] = 8'h5C; out_ready = 1'b1;
    repeat (2) step();
    out_ready = 1'b0;
    repeat (5) step();
    out_ready = 1'b1;
    repeat (3) step();
    req = 4'b0000;
    repeat (2) step();

    // Source 1 drops after two transfers; source 0 wins next.
    req = 4'b0010; d[1] = 8'h7E; d[0] = 8'h0D;
    repeat (3) step();
    req = 4'b0001;
    repeat (4) step();
    req = 4'b0000;
    repeat (2) step();

    // Single persistent requester on source 3.
    req = 4'b1000; d[3] = 8'hC3;
    repeat (10) step();
    req = 4'b0000;
    repeat (2) step();

    // Randomised traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      if ($urandom_range(0, 399) == 0) async_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
